// File: rtl/gate_vector_checker_pkg.sv
// ============================================================================
// gate_vector_checker_pkg : shared state encodings and vector constants
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_vector_checker_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_DRIVE = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_CHECK = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_vector_checker_ref_model.sv
// ============================================================================
// gate_ref_model : combinational golden model of the checked gate output f1
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_ref_model
  import gate_vector_checker_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic exp_f1
);

  // c takes no part in f1; it is kept on the port so the model mirrors the gate pins
  logic unused_c;
  assign unused_c = c;

  assign exp_f1 = nand2(a, b);

endmodule

`default_nettype wire

// File: rtl/gate_vector_checker.sv
// ============================================================================
// gate_vector_checker : sweeps a,b,c through all 8 vectors LOOPS times and
//                       checks f1 against NAND(a,b), logging f2 on the last loop
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_vector_checker
  import gate_vector_checker_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 1,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stim_a,
  output logic             stim_b,
  output logic             stim_c,
  input  logic             resp_f1,
  input  logic             resp_f2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       fail_vec,
  output logic [7:0]       f2_log
);

  localparam int WAIT_W = $clog2(SETTLE + 1);
  localparam int LOOP_W = $clog2(LOOPS + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX   = '1;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [LOOP_W-1:0]  loop_q, loop_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [VEC_W-1:0]   stim_q, stim_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic [2:0]         fail_q, fail_d;
  logic [7:0]         f2_q, f2_d;

  logic exp_f1;
  logic mismatch;
  logic last_vec;

  gate_ref_model u_ref (
    .a      (stim_q[2]),
    .b      (stim_q[1]),
    .c      (stim_q[0]),
    .exp_f1 (exp_f1)
  );

  assign mismatch = (resp_f1 != exp_f1);
  assign last_vec = (vec_q == VEC_LAST) && (loop_q == LOOP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_DRIVE;
      S_DRIVE: state_d = S_WAIT;
      S_WAIT:  if (wait_q == WAIT_LAST) state_d = S_CHECK;
      S_CHECK: state_d = last_vec ? S_DONE : S_DRIVE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
  end

  always_comb begin
    vec_d  = vec_q;
    loop_d = loop_q;
    wait_d = wait_q;
    stim_d = stim_q;
    err_d  = err_q;
    pass_d = pass_q;
    fail_d = fail_q;
    f2_d   = f2_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d  = '0;
          loop_d = '0;
          wait_d = '0;
          stim_d = '0;
          err_d  = '0;
          pass_d = 1'b0;
          fail_d = '0;
          f2_d   = '0;
        end
      end
      S_WAIT: begin
        wait_d = (wait_q == WAIT_LAST) ? '0 : WAIT_W'(wait_q + 1'b1);
      end
      S_CHECK: begin
        if (mismatch) begin
          // err_q==0 marks the first mismatch; saturation never brings it back to 0
          if (err_q == '0) fail_d = vec_q;
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        end
        if (loop_q == LOOP_LAST) f2_d[vec_q] = resp_f2;
        vec_d = VEC_W'(vec_q + 1'b1);
        if (vec_q == VEC_LAST) loop_d = LOOP_W'(loop_q + 1'b1);
        if (last_vec) begin
          stim_d = '0;
          pass_d = (err_d == '0);
        end else begin
          stim_d = vec_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q  <= '0;
      loop_q <= '0;
      wait_q <= '0;
      stim_q <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= '0;
      f2_q   <= '0;
    end else begin
      vec_q  <= vec_d;
      loop_q <= loop_d;
      wait_q <= wait_d;
      stim_q <= stim_d;
      err_q  <= err_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      f2_q   <= f2_d;
    end
  end

  assign stim_a    = stim_q[2];
  assign stim_b    = stim_q[1];
  assign stim_c    = stim_q[0];
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign f2_log    = f2_q;

endmodule

`default_nettype wire
